// File: rtl/lsu_if.sv
// lsu_if: request/response handshake and RAM port bundle for the load/store unit.
// The slave modport is the LSU itself; the master modport is its environment
// (execute stage issuing requests plus the data RAM answering reads).
interface lsu_if;
  // request channel from the execute stage
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // response channel back to the execute stage
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // single-port word-wide data RAM
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    output mem_rdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    input  mem_rdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit in front of a word-wide single-port RAM.
// Sub-word stores are done as read-modify-write because the RAM has no byte
// enables; load results are sign- or zero-extended from the addressed lane.
module lsu (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_t      state;
  state_t      state_next;

  // request fields captured at accept; they stay valid until the next accept
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // old RAM word for a sub-word store, and the held response
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;
  logic [31:0] merged_value;

  assign accept = (state == IDLE) && bus.req_valid;

  // classify the incoming request: illegal size or misaligned access
  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = bus.req_addr[0];
      SIZE_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
  end

  // pick the addressed little-endian lane out of the RAM word and extend it
  always_comb begin
    lane_byte  = 8'h00;
    lane_half  = 16'h0000;
    load_value = bus.mem_rdata;
    case (addr_q[1:0])
      2'd0:    lane_byte = bus.mem_rdata[7:0];
      2'd1:    lane_byte = bus.mem_rdata[15:8];
      2'd2:    lane_byte = bus.mem_rdata[23:16];
      default: lane_byte = bus.mem_rdata[31:24];
    endcase
    lane_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      SIZE_BYTE: load_value = uns_q ? {24'h000000, lane_byte}
                                    : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_value = uns_q ? {16'h0000, lane_half}
                                    : {{16{lane_half[15]}}, lane_half};
      default:   load_value = bus.mem_rdata;
    endcase
  end

  // overlay the store data onto the old word, leaving other lanes untouched
  always_comb begin
    merged_value = merge_q;
    if (size_q == SIZE_HALF) begin
      if (addr_q[1]) begin
        merged_value[31:16] = wdata_q[15:0];
      end else begin
        merged_value[15:0] = wdata_q[15:0];
      end
    end else begin
      case (addr_q[1:0])
        2'd0:    merged_value[7:0]   = wdata_q[7:0];
        2'd1:    merged_value[15:8]  = wdata_q[7:0];
        2'd2:    merged_value[23:16] = wdata_q[7:0];
        default: merged_value[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // sequencing: errors answer directly, word stores skip the read, sub-word
  // stores read first and then write exactly once
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (!bus.req_we) begin
            state_next = RD;
          end else if (bus.req_size == SIZE_WORD) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = bus.rsp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // capture the request on accept and the RAM word during the read cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      rdata_q <= 32'h0;
      err_q   <= req_err;
    end else if (state == RD) begin
      if (we_q) begin
        merge_q <= bus.mem_rdata;
      end else begin
        rdata_q <= load_value;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state == WR);
  assign bus.mem_addr  = {2'b00, addr_q[31:2]};
  assign bus.mem_wdata = (state != WR)           ? 32'h0 :
                         (size_q == SIZE_WORD)   ? wdata_q : merged_value;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of the lsu against a behavioural
// model of memory semantics; responses are compared by a scoreboard monitor.
module tb_lsu;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  lsu_if bus ();

  lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rsp_t        exp_q[$];
  rsp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_pulses = 0;
  int          expected_writes = 0;
  logic [31:0] ref_mem[64];
  bit   [31:0] ram_val[64];
  bit          ram_wr[64];
  bit          rand_ready = 1'b0;
  bit          ready_force = 1'b1;

  // free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_default(input logic [31:0] idx);
    return (idx == 32'd0) ? 32'd5 : idx + 32'd2;
  endfunction

  // bench RAM: combinational read, initial contents follow the default rule
  always_comb begin
    if (bus.mem_addr < 32'd64) begin
      bus.mem_rdata = ram_wr[bus.mem_addr[5:0]] ? ram_val[bus.mem_addr[5:0]]
                                                : ram_default(bus.mem_addr);
    end else begin
      bus.mem_rdata = ram_default(bus.mem_addr);
    end
  end

  // bench RAM: synchronous write, plus a count of every write pulse
  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_pulses <= we_pulses + 1;
      if (bus.mem_addr < 32'd64) begin
        ram_val[bus.mem_addr[5:0]] <= bus.mem_wdata;
        ram_wr[bus.mem_addr[5:0]]  <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] idx);
    return (idx < 32'd64) ? ref_mem[idx[5:0]] : ram_default(idx);
  endfunction

  // reference: apply the request to the memory model and queue its response
  task automatic model_apply(input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr,
                             input logic [31:0] wdata);
    rsp_t        e;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] lane;
    int          sh;
    e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00);
    e.rdata = 32'h0;
    if (!e.err) begin
      word = model_read({2'b00, addr[31:2]});
      sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) :
             (size == 2'd1) ? 16 * int'(addr[1]) : 0;
      mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (we) begin
        ref_mem[addr[7:2]] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        expected_writes++;
      end else begin
        lane = (word >> sh) & mask;
        if (!uns && size == 2'd0 && lane[7])  lane = lane | 32'hFFFF_FF00;
        if (!uns && size == 2'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
        e.rdata = lane;
      end
    end
    exp_q.push_back(e);
  endtask

  // present a request and hold it until it is accepted (bounded)
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit expect_rsp);
    bit done;
    done             = 1'b0;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else if (expect_rsp) begin
      model_apply(we, size, uns, addr, wdata);
    end
  endtask

  // follow one request from accept to its first response cycle
  task automatic track_rsp(output int lat, output int nwe,
                           output logic [31:0] waddr, output logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
    lat = 0; nwe = 0; waddr = 32'h0; wdata = 32'h0; rdata = 32'h0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        nwe++;
        waddr = bus.mem_addr;
        wdata = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        lat   = i;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
    end
    if (lat == 0) checkOutput("response_timeout", 32'd0, 32'd1);
  endtask

  // drive rsp_ready just after each rising edge, random or forced
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // scoreboard monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_response", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
        checkOutput("sb_rsp_rdata", bus.rsp_rdata, mon_e.rdata);
      end
    end
  end

  // hard stop if something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int          lat, nwe, seen, pulses_before;
  logic [31:0] wa, wd, rd;
  logic        er;
  logic [31:0] ext_addr[4]  = '{32'h22, 32'h23, 32'h20, 32'h22};
  logic [1:0]  ext_size[4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
  logic        ext_uns[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ext_exp[4]   = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF};
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  // main sequence: reset, directed cases, random traffic, summary
  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = ram_default(32'(i));
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    $display("[TB] word load");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("wload_latency", 32'(lat), 32'd2);
    checkOutput("wload_no_write", 32'(nwe), 32'd0);
    checkOutput("wload_rdata", rd, 32'h5);
    checkOutput("wload_err", 32'(er), 32'd0);

    $display("[TB] byte store read-modify-write");
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("bstore_latency", 32'(lat), 32'd3);
    checkOutput("bstore_writes", 32'(nwe), 32'd1);
    checkOutput("bstore_waddr", wa, 32'd4);
    checkOutput("bstore_wdata", wd, 32'h0000_AB06);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("bstore_readback", rd, 32'h0000_AB06);

    $display("[TB] extension");
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("wstore_latency", 32'(lat), 32'd2);
    checkOutput("wstore_wdata", wd, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, ext_size[i], ext_uns[i], ext_addr[i], 32'h0, 1'b1);
      track_rsp(lat, nwe, wa, wd, rd, er);
      checkOutput("ext_rdata", rd, ext_exp[i]);
    end

    $display("[TB] errors");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("err_wload_latency", 32'(lat), 32'd1);
    checkOutput("err_wload_flag", 32'(er), 32'd1);
    checkOutput("err_wload_rdata", rd, 32'd0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h3, 32'h1234, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("err_hstore_latency", 32'(lat), 32'd1);
    checkOutput("err_hstore_flag", 32'(er), 32'd1);
    checkOutput("err_hstore_no_write", 32'(nwe), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("err_hstore_ram_kept", rd, 32'h5);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("err_size3_flag", 32'(er), 32'd1);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("wrap_mem_addr", bus.mem_addr, 32'h3FFF_FFFF);
    checkOutput("wrap_rdata", rd, 32'h4000_0001);

    $display("[TB] backpressure");
    ready_force = 1'b0;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b1);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'hC; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !bus.rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", bus.rsp_rdata, 32'h4);
      checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("bp_mem_addr", bus.mem_addr, 32'd2);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_still_busy", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_idle_after_hs", 32'(bus.req_ready), 32'd1);
    checkOutput("bp_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    checkOutput("bp_not_yet_accepted", bus.mem_addr, 32'd2);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    model_apply(1'b0, 2'd2, 1'b0, 32'hC, 32'h0);
    @(negedge clk);
    checkOutput("bp_competing_accepted", bus.mem_addr, 32'd3);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("bp_competing_rdata", rd, 32'h5);

    $display("[TB] reset during read-modify-write");
    @(posedge clk);
    pulses_before = we_pulses;
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0);
    checkOutput("rmw_busy_before_reset", 32'(bus.req_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("rmw_reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rmw_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rmw_reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rmw_reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("rmw_reset_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rmw_reset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rmw_reset_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("rmw_no_write", 32'(we_pulses - pulses_before), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    track_rsp(lat, nwe, wa, wd, rd, er);
    checkOutput("rmw_word0_kept", rd, 32'h5);

    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 255));
      r_wdata = $urandom;
      if (!r_we && $urandom_range(0, 19) == 0) r_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      applyStimulus(r_we, r_size, r_uns, r_addr, r_wdata, 1'b1);
    end
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    checkOutput("total_write_pulses", 32'(we_pulses), 32'(expected_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits between the core's execute stage and the word-wide single-port data RAM. It accepts byte, halfword and word load/store requests on a valid/ready handshake and drives the RAM's `we`/`addr`/`data_i` port, sampling its combinational `data_o`. Sub-word stores become a read-modify-write, because the RAM has no byte enables. Load results are sign- or zero-extended.

## Interface
Parameters:
- none. All widths are fixed at 32 bits. RAM addresses are word indices.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `req_unsigned` input 1: zero-extend load result; ignored for stores and word loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` output 1: response present; held until accepted.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_rdata` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: misaligned or illegal-size request.
- `mem_we` output 1: RAM write enable.
- `mem_addr` output 32: RAM word index, equal to latched `req_addr[31:2]` zero-extended.
- `mem_wdata` output 32: RAM write data.
- `mem_rdata` input 32: RAM combinational read data for `mem_addr`.

## Operation
- States: IDLE, RD, WR, RESP.
- **Accept.** A request is accepted in IDLE when `req_valid` is high. On accept the unit latches we, size, unsigned, addr and wdata.
- **Error check.** The request is an error if size is 3, if it is a half with addr[0]=1, or if it is a word with addr[1:0]≠0.
- **Routing from IDLE on accept:**
  - error → RESP with `rsp_err`=1; no RAM access.
  - load → RD.
  - word store → WR.
  - byte or half store → RD.
- **RD.**
  - Load: capture `mem_rdata` and form the result, then go to RESP.
  - Sub-word store: capture `mem_rdata` into the merge register, then go to WR.
- **Load extraction.** Lanes are little-endian and selected by addr[1:0].
  - Byte = word[8*a+7:8*a].
  - Half = word[16*a1+15:16*a1], where a1 = addr[1].
  - Sign-extend unless `req_unsigned`.
- **WR.** `mem_we`=1 for exactly one cycle, then go to RESP.
  - Word store: `mem_wdata` = wdata.
  - Sub-word store: `mem_wdata` = merge register with the addressed lane replaced by wdata[7:0] (byte) or wdata[15:0] (half); other lanes are preserved bit-exact.
- **RESP.** `rsp_valid`=1. On `rsp_ready`, go to IDLE. `rsp_rdata` and `rsp_err` stay stable while waiting.
- `mem_we` is asserted only in WR; there is never more than one write per request.
- `mem_addr` holds the latched word index from accept until the next accept.
- No request queuing; at most one request is in flight.
- `req_valid` while not in IDLE is ignored; the requester must hold it.

## Timing
- Accept edge = T, at the end of the IDLE cycle with valid and ready both high.
- Latency to the first `rsp_valid` cycle:
  - error: T+1.
  - load: T+2.
  - word store: T+2 (write cycle T+1).
  - sub-word store: T+3 (read T+1, write T+2).
- Throughput without backpressure:
  - one load every 3 cycles;
  - one sub-word store every 4 cycles.
- When `rsp_valid` and `rsp_ready` are both high at edge E, the next cycle is IDLE and `req_ready` is 1 at E+1. There is no same-cycle request/response overlap.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, merge register 0.
- Reset asserted mid-operation (any state):
  - outputs take reset values immediately, without waiting for `clk`;
  - `mem_we` drops at once, so an in-progress RMW commits nothing unless the WR edge already occurred;
  - no response is issued for the aborted request.
- Reset deassertion is synchronised externally; the first accept is possible at the first edge after release.
- Address wrap: `req_addr`=0xFFFFFFFC gives word index 0x3FFFFFFF. No other address translation is applied.

## Test plan
Bench RAM model: word 0 = 5, word n = n+2. Read is combinational and write is synchronous.
- **Word load.** Word load at 0x00000000 → `rsp_valid` at T+2, `rsp_rdata`=0x00000005, `rsp_err`=0, `mem_we` never high.
- **Byte-store RMW.** Byte store 0xAB at 0x00000011 → read T+1, write T+2 with `mem_addr`=4 and `mem_wdata`=0x0000AB06, `rsp_valid` at T+3. A following word load at 0x10 returns 0x0000AB06.
- **Extension.** Word store 0x80FF7F01 at 0x20, then loads:
  - signed byte at 0x22 → 0xFFFFFFFF;
  - unsigned byte at 0x23 → 0x00000080;
  - signed half at 0x20 → 0x00007F01;
  - signed half at 0x22 → 0xFFFF80FF.
- **Errors.**
  - Word load at 0x00000006 → `rsp_err`=1 at T+1 and `rsp_rdata`=0.
  - Half store at 0x00000003 → `rsp_err`=1 at T+1, `mem_we` stays 0, RAM unchanged.
  - `req_size`=3 → `rsp_err`=1.
- **Backpressure.** Load at 0x8 with `rsp_ready` held 0 for 5 cycles → `rsp_valid`=1 and `rsp_rdata`=0x00000004 stable throughout. `req_ready`=0, and a competing `req_valid` is not accepted until the cycle after the response handshake.
- **Reset mid-RMW.** Half store 0xBEEF at 0x0 with `reset` driven low during RD → all outputs at reset values before the next edge, `mem_we` never pulses, word 0 still reads 5 after release.
